// File: rtl/add_reservation_station_pkg.sv
// Shared types and helpers for the Tomasulo-style execution cluster.
package add_reservation_station_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int AGE_W  = 3;

  localparam logic [TAG_W-1:0] NO_TAG = '0;

  // Tag ranges owned by each reservation station in the cluster
  localparam int ADD_TAG_LO = 1;
  localparam int ADD_TAG_HI = 8;
  localparam int MUL_TAG_LO = 9;
  localparam int MUL_TAG_HI = 15;

  typedef struct packed {
    logic              busy;
    logic              sub;
    logic [TAG_W-1:0]  qj;
    logic [DATA_W-1:0] vj;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vk;
    logic [AGE_W-1:0]  age;
  } rs_entry_t;

  // Two's-complement negation, wraps modulo 2^DATA_W
  function automatic logic [DATA_W-1:0] neg2(input logic [DATA_W-1:0] v);
    return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/add_reservation_station_age_select.sv
// Oldest-ready picker: among ready entries, grants the one with the smallest age rank.
module rs_age_select
  import add_reservation_station_pkg::*;
#(
  parameter int N_ENT = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_ENT-1:0]       ready_i,
  input  logic [N_ENT*AGE_W-1:0] rank_i,
  output logic [N_ENT-1:0]       grant_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   any_o
);

  logic [AGE_W-1:0] best_rank;

  // Linear scan keeping the smallest rank seen among ready entries
  always_comb begin
    best_rank = '1;
    idx_o     = '0;
    any_o     = 1'b0;
    for (int i = 0; i < N_ENT; i++) begin
      if (ready_i[i] && (!any_o || (rank_i[i*AGE_W +: AGE_W] < best_rank))) begin
        any_o     = 1'b1;
        best_rank = rank_i[i*AGE_W +: AGE_W];
        idx_o     = IDX_W'(i);
      end
    end
    grant_o = any_o ? (N_ENT'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/add_reservation_station.sv
// Reservation station for the integer add/sub unit: holds issued ops until both
// operands arrive (snooping the CDB) and dispatches the oldest ready op.
module add_reservation_station
  import add_reservation_station_pkg::*;
#(
  parameter int N_ENT   = 4,
  parameter int TAG_W   = 4,
  parameter int RS_BASE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              issue_sub,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [31:0]       issue_vj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [31:0]       issue_vk,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [31:0]       cdb_data,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [31:0]       disp_a,
  output logic [31:0]       disp_b,
  output logic [TAG_W-1:0]  disp_tag
);

  localparam int IDX_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;

  logic [N_ENT-1:0]  busy_q, busy_d;
  logic [N_ENT-1:0]  sub_q, sub_d;
  logic [TAG_W-1:0]  qj_q [N_ENT];
  logic [TAG_W-1:0]  qj_d [N_ENT];
  logic [TAG_W-1:0]  qk_q [N_ENT];
  logic [TAG_W-1:0]  qk_d [N_ENT];
  logic [DATA_W-1:0] vj_q [N_ENT];
  logic [DATA_W-1:0] vj_d [N_ENT];
  logic [DATA_W-1:0] vk_q [N_ENT];
  logic [DATA_W-1:0] vk_d [N_ENT];
  logic [AGE_W-1:0]  age_q [N_ENT];
  logic [AGE_W-1:0]  age_d [N_ENT];

  logic [N_ENT-1:0]       ready_vec;
  logic [N_ENT*AGE_W-1:0] rank_flat;
  logic [N_ENT-1:0]       sel_grant;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_any;

  logic [IDX_W-1:0] free_idx;
  logic             has_free;
  logic [AGE_W:0]   occ;
  logic             fire, accept, byp_j, byp_k;

  // Per-entry readiness, rank vector, lowest free slot and occupancy from registered state
  always_comb begin
    ready_vec = '0;
    rank_flat = '0;
    free_idx  = '0;
    has_free  = 1'b0;
    occ       = '0;
    for (int i = 0; i < N_ENT; i++) begin
      ready_vec[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
      rank_flat[i*AGE_W +: AGE_W] = age_q[i];
      occ = occ + {{AGE_W{1'b0}}, busy_q[i]};
    end
    for (int i = N_ENT - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx = IDX_W'(i);
        has_free = 1'b1;
      end
    end
  end

  rs_age_select #(
    .N_ENT (N_ENT),
    .IDX_W (IDX_W)
  ) u_sel (
    .ready_i (ready_vec),
    .rank_i  (rank_flat),
    .grant_o (sel_grant),
    .idx_o   (sel_idx),
    .any_o   (sel_any)
  );

  // Issue and dispatch handshakes; outputs are zero when nothing is selected
  always_comb begin
    issue_ready = has_free;
    issue_tag   = TAG_W'(RS_BASE) + TAG_W'(free_idx);
    accept      = issue_valid && has_free;
    fire        = sel_any && disp_ready;
    byp_j       = cdb_valid && (issue_qj != '0) && (issue_qj == cdb_tag);
    byp_k       = cdb_valid && (issue_qk != '0) && (issue_qk == cdb_tag);
    disp_valid  = sel_any;
    disp_a      = '0;
    disp_b      = '0;
    disp_tag    = '0;
    if (sel_any) begin
      disp_a   = vj_q[sel_idx];
      disp_b   = sub_q[sel_idx] ? neg2(vk_q[sel_idx]) : vk_q[sel_idx];
      disp_tag = TAG_W'(RS_BASE) + TAG_W'(sel_idx);
    end
  end

  // Next state: CDB snoop, dispatch free + age compaction, issue allocate, flush clear
  always_comb begin
    busy_d = busy_q;
    sub_d  = sub_q;
    for (int i = 0; i < N_ENT; i++) begin
      qj_d[i]  = qj_q[i];
      qk_d[i]  = qk_q[i];
      vj_d[i]  = vj_q[i];
      vk_d[i]  = vk_q[i];
      age_d[i] = age_q[i];
      if (busy_q[i] && cdb_valid && (qj_q[i] != '0) && (qj_q[i] == cdb_tag)) begin
        vj_d[i] = cdb_data;
        qj_d[i] = '0;
      end
      if (busy_q[i] && cdb_valid && (qk_q[i] != '0) && (qk_q[i] == cdb_tag)) begin
        vk_d[i] = cdb_data;
        qk_d[i] = '0;
      end
      if (fire && busy_q[i] && (age_q[i] > age_q[sel_idx])) begin
        age_d[i] = age_q[i] - 1'b1;
      end
    end
    if (fire) begin
      busy_d = busy_d & ~sel_grant;
    end
    if (accept) begin
      busy_d[free_idx] = 1'b1;
      sub_d[free_idx]  = issue_sub;
      qj_d[free_idx]   = byp_j ? '0 : issue_qj;
      vj_d[free_idx]   = byp_j ? cdb_data : issue_vj;
      qk_d[free_idx]   = byp_k ? '0 : issue_qk;
      vk_d[free_idx]   = byp_k ? cdb_data : issue_vk;
      // A simultaneous dispatch removes an older entry, so the newcomer lands one rank lower
      age_d[free_idx]  = occ[AGE_W-1:0] - AGE_W'(fire);
    end
    if (flush) begin
      busy_d = '0;
    end
  end

  // Occupancy is the only reset state; payload is qualified by busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Entry payload registers
  always_ff @(posedge clk) begin
    sub_q <= sub_d;
    for (int i = 0; i < N_ENT; i++) begin
      qj_q[i]  <= qj_d[i];
      qk_q[i]  <= qk_d[i];
      vj_q[i]  <= vj_d[i];
      vk_q[i]  <= vk_d[i];
      age_q[i] <= age_d[i];
    end
  end

endmodule

// File: tb/tb_add_reservation_station.sv
// Bench for add_reservation_station: directed scenarios plus random traffic,
// all checked against an issue-order reference model.
module tb_add_reservation_station;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush, issue_valid, issue_ready, issue_sub;
  logic [3:0]  issue_qj, issue_qk, issue_tag, cdb_tag, disp_tag;
  logic [31:0] issue_vj, issue_vk, cdb_data, disp_a, disp_b;
  logic        cdb_valid, disp_valid, disp_ready;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: plain per-slot records ordered by an issue sequence number
  bit          m_busy [N];
  bit          m_sub  [N];
  logic [3:0]  m_qj   [N];
  logic [3:0]  m_qk   [N];
  logic [31:0] m_vj   [N];
  logic [31:0] m_vk   [N];
  int          m_seq  [N];
  int          seq_ctr = 0;
  int          e_sel;
  logic [31:0] saved_a;

  add_reservation_station #(.N_ENT(4), .TAG_W(4), .RS_BASE(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_sub(issue_sub),
    .issue_qj(issue_qj), .issue_vj(issue_vj), .issue_qk(issue_qk), .issue_vk(issue_vk),
    .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_a(disp_a), .disp_b(disp_b), .disp_tag(disp_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int oldest_ready();
    int best = -1;
    for (int i = 0; i < N; i++)
      if (m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0 && (best < 0 || m_seq[i] < m_seq[best]))
        best = i;
    return best;
  endfunction

  // Apply inputs mid-cycle and compare the combinational outputs with the model
  task automatic drive(input bit iv, input bit sb, input logic [3:0] qj, input logic [31:0] vj,
                       input logic [3:0] qk, input logic [31:0] vk,
                       input bit cv, input logic [3:0] ct, input logic [31:0] cd,
                       input bit dr, input bit fl);
    int fr;
    @(negedge clk);
    issue_valid = iv; issue_sub = sb; issue_qj = qj; issue_vj = vj;
    issue_qk = qk; issue_vk = vk; cdb_valid = cv; cdb_tag = ct; cdb_data = cd;
    disp_ready = dr; flush = fl;
    #1;
    if (!rst_n) return;
    fr    = lowest_free();
    e_sel = oldest_ready();
    check("issue_ready", {31'd0, issue_ready}, {31'd0, fr >= 0});
    if (fr >= 0) check("issue_tag", {28'd0, issue_tag}, 32'(fr + 1));
    check("disp_valid", {31'd0, disp_valid}, {31'd0, e_sel >= 0});
    if (e_sel >= 0) begin
      check("disp_a", disp_a, m_vj[e_sel]);
      check("disp_b", disp_b, m_sub[e_sel] ? (32'd0 - m_vk[e_sel]) : m_vk[e_sel]);
      check("disp_tag", {28'd0, disp_tag}, 32'(e_sel + 1));
    end
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic tick();
    int fr;
    fr = lowest_free();
    for (int i = 0; i < N; i++) begin
      if (m_busy[i] && cdb_valid && m_qj[i] != 0 && m_qj[i] == cdb_tag) begin
        m_qj[i] = 0; m_vj[i] = cdb_data;
      end
      if (m_busy[i] && cdb_valid && m_qk[i] != 0 && m_qk[i] == cdb_tag) begin
        m_qk[i] = 0; m_vk[i] = cdb_data;
      end
    end
    if (e_sel >= 0 && disp_ready) m_busy[e_sel] = 0;
    if (issue_valid && fr >= 0) begin
      m_busy[fr] = 1; m_sub[fr] = issue_sub; m_seq[fr] = seq_ctr++;
      if (cdb_valid && issue_qj != 0 && issue_qj == cdb_tag) begin m_qj[fr] = 0; m_vj[fr] = cdb_data; end
      else begin m_qj[fr] = issue_qj; m_vj[fr] = issue_vj; end
      if (cdb_valid && issue_qk != 0 && issue_qk == cdb_tag) begin m_qk[fr] = 0; m_vk[fr] = cdb_data; end
      else begin m_qk[fr] = issue_qk; m_vk[fr] = issue_vk; end
    end
    if (flush || !rst_n) for (int i = 0; i < N; i++) m_busy[i] = 0;
    @(posedge clk);
  endtask

  task automatic idle(input bit dr);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, dr, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_busy[i] = 0;
    e_sel = -1;
    rst_n = 1'b0;
    // Reset for two cycles
    idle(0); tick();
    idle(0); tick();
    rst_n = 1'b1;
    idle(0);
    check("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    check("rst_disp_valid", {31'd0, disp_valid}, 32'd0);
    check("rst_disp_a", disp_a, 32'd0);
    check("rst_disp_b", disp_b, 32'd0);
    check("rst_issue_tag", {28'd0, issue_tag}, 32'd1);
    tick();

    // Add with both operands present: dispatchable next cycle
    drive(1, 0, 0, 32'h25, 0, 32'h1D, 0, 0, 0, 0, 0); tick();
    idle(0);
    check("add_valid", {31'd0, disp_valid}, 32'd1);
    check("add_a", disp_a, 32'h25);
    check("add_b", disp_b, 32'h1D);
    check("add_tag", {28'd0, disp_tag}, 32'd1);
    tick();
    idle(1); tick();

    // Subtract: second operand negated
    drive(1, 1, 0, 32'd10, 0, 32'd3, 0, 0, 0, 0, 0); tick();
    idle(1);
    check("sub_b", disp_b, 32'hFFFF_FFFD);
    check("sub_sum", disp_a + disp_b, 32'd7);
    tick();
    // Negation corner cases
    drive(1, 1, 0, 32'd5, 0, 32'd0, 0, 0, 0, 0, 0); tick();
    idle(1); check("sub_zero", disp_b, 32'd0); tick();
    drive(1, 1, 0, 32'd5, 0, 32'h8000_0000, 0, 0, 0, 0, 0); tick();
    idle(1); check("sub_min", disp_b, 32'h8000_0000); tick();

    // CDB wake-up
    drive(1, 0, 4'd5, 0, 0, 32'd4, 0, 0, 0, 0, 0); tick();
    idle(0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 4'd5, 32'h100, 0, 0);
    check("wake_same_cycle", {31'd0, disp_valid}, 32'd0);
    tick();
    idle(0);
    check("wake_valid", {31'd0, disp_valid}, 32'd1);
    check("wake_a", disp_a, 32'h100);
    tick();
    idle(1); tick();
    // Issue/CDB bypass
    drive(1, 0, 0, 32'd2, 4'd6, 32'hDEAD, 1, 4'd6, 32'd9, 0, 0); tick();
    idle(0);
    check("bypass_valid", {31'd0, disp_valid}, 32'd1);
    check("bypass_b", disp_b, 32'd9);
    tick();
    idle(1); tick();

    // Fill, backpressure, age ordering
    for (int i = 0; i < N; i++) begin
      drive(1, 0, 4'(9 + i), 32'h11 * (i + 1), 0, 32'd1, 0, 0, 0, 0, 0); tick();
    end
    drive(1, 0, 0, 32'h77, 0, 32'h77, 0, 0, 0, 0, 0);
    check("full_ready", {31'd0, issue_ready}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 4'd11, 32'h300, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 4'd9, 32'h100, 0, 0);
    check("order_first", {28'd0, disp_tag}, 32'd3);
    tick();
    idle(0);
    check("order_oldest", {28'd0, disp_tag}, 32'd1);
    saved_a = disp_a;
    tick();
    idle(0);
    check("stall_tag", {28'd0, disp_tag}, 32'd1);
    check("stall_a", disp_a, saved_a);
    tick();
    idle(1); tick();
    idle(0);
    check("order_next", {28'd0, disp_tag}, 32'd3);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 4'd10, 32'h200, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 4'd12, 32'h400, 1, 0); tick();
    for (int i = 0; i < 4; i++) begin idle(1); tick(); end

    // Flush beats issue
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 4'd9, 32'd1, 0, 32'd1, 0, 0, 0, 0, 0); tick();
    end
    drive(1, 0, 0, 32'd1, 0, 32'd2, 0, 0, 0, 1, 1); tick();
    idle(0);
    check("flush_ready", {31'd0, issue_ready}, 32'd1);
    check("flush_disp", {31'd0, disp_valid}, 32'd0);
    check("flush_tag", {28'd0, issue_tag}, 32'd1);
    tick();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 12)) : 4'd0, $urandom,
            ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 12)) : 4'd0, $urandom,
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 12)), $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
